cft_alu_core: RTL and testbench
===============================

// Module: cft_alu_core
// PURPOSE
//  16-bit processor ALU. Holds operand B in an internal register loaded from IBUS, takes
//  operand A from AC, and drives the selected result back onto IBUS while RUNIT selects
//  an ALU operation. Produces carry/overflow/roll flags and a phased flag-write strobe.
//  The strobe's phase comes from an internal 4-phase sequencer that replaces the old
//  multi-clock generator.
// PARAMETERS
//  WIDTH  16  data path width (IBUS, AC, B register, result)
// PORTS
//  clk       in     1      single system clock, all state on rising edge
//  reset     in     1      synchronous, active-high reset
//  runit     in     4      unit/op select: see BEHAVIOUR
//  ir        in     16     instruction register; ir[3:0] = roll distance
//  ac        in     16     operand A (accumulator)
//  fl        in     1      current link flag (carry-in to ADD, 17th bit for ROLL)
//  nwalu     in     1      active-low write strobe: load B from ibus
//  ibus      inout  16     shared bus; read for B load, driven with result
//  nflstrobe out    1      active-low flag-write strobe
//  fv        out    1      signed overflow from ADD
//  nfltadd   out    1      active-low carry-out/new-link from ADD
//  roll16    out    1      new link bit produced by ROLL
//  isroll    out    1      high while a ROLL operation is selected
//  phase     out    2      current sequencer phase, 0..3
// BEHAVIOUR
//  - Op codes (runit): 0000..0011 idle. 0100 ROLL, 0101 NOT, 0110 CS1, 0111 CS2.
//    1000 ADD, 1001 AND, 1010 OR, 1011 XOR. 11xx is treated as idle.
//  - B register: on clk edge with nwalu=0, B <= ibus. Reset clears B to 0.
//  - Result is combinational from ac, B, fl, ir (zero latency).
//    ADD  = ac + B + fl, truncated to 16 bits.
//    AND  = ac & B.  OR = ac | B.  XOR = ac ^ B.  NOT = ~ac.
//    CS1  = B (pass-through).  CS2 = ac (pass-through).
//    ROLL = rotate the 17-bit word {fl, ac} left by ir[3:0] places;
//           result = low 16 bits, new link = bit 16. Distance 0 returns ac unchanged.
//  - ibus is driven with the result when runit is an ALU op and reset=0; otherwise high-Z.
//    The drive follows runit combinationally.
//    The external controller guarantees nwalu=1 whenever the ALU drives ibus.
//  - ADD carry and overflow:
//    nfltadd = ~carry_out(bit 16) during ADD; nfltadd = 1 for all other ops and idle.
//    fv = (ac[15]==B[15]) && (sum[15]!=ac[15]) during ADD; 0 otherwise.
//  - ROLL flags: isroll = (runit==ROLL); roll16 = isroll & new link. Both are 0 for other ops.
//  - Sequencer: 2-bit counter, reset to 0, increments every clk and wraps 3->0.
//    The phase output equals the counter.
//  - Flag strobe: nflstrobe = 0 while phase==3 and runit is ADD or ROLL, else 1.
//    It is registered; it asserts on the edge entering phase 3 and lasts exactly one cycle.
//  - Reset values: B=0, phase=0, nflstrobe=1, ibus high-Z; all combinational flags are
//    inactive (fv=0, nfltadd=1, roll16=0, isroll=0) because runit is forced idle in reset.
//  - Reset asserted mid-operation releases ibus in the same cycle.
//    The sequencer restarts at phase 0 once reset deasserts.
//  - Simultaneous nwalu=0 and ALU op: the bus value loads into B; the result uses the old B.
// STRUCTURE
//  - Shared package cft_alu_pkg holds the RUNIT op-code localparams
//    (ALU_IDLE, ALU_ROLL, ALU_NOT, ALU_CS1, ALU_CS2, ALU_ADD, ALU_AND, ALU_OR, ALU_XOR)
//    and WIDTH.
//  - Sub-module cft_alu_phase_gen: the 2-bit phase sequencer.
//  - The datapath, B register, tristate drive and flags stay in the top module.
// TESTING
//  - OR: load B=16'h0F0F, ac=16'h5431, fl=0, runit=1010 -> ibus=16'h5F3F, nfltadd=1,
//    fv=0, isroll=0, roll16=0.
//    Sweep a,b with stride 21553 mod 65536 over 1024x1024 pairs; every result = a|b.
//  - ADD: B=16'h0001, ac=16'hFFFF, fl=0 -> ibus=16'h0000, nfltadd=0, fv=0.
//    ac=16'h7FFF -> ibus=16'h8000, nfltadd=1, fv=1.
//  - ROLL: ac=16'h8001, fl=0, ir[3:0]=1, runit=0100 -> ibus=16'h0002, isroll=1, roll16=1.
//    nflstrobe is low for one cycle at phase 3.
//  - Idle/bus release: runit=0000 -> ibus high-Z. nwalu=0 with ibus=16'hA5A5, then NOT is
//    unaffected; CS1 -> ibus=16'hA5A5.
//  - Reset mid-op: assert reset during ADD -> ibus high-Z, nflstrobe=1, B=0, phase=0 next cycle.

Source files
------------

// File: rtl/cft_alu_pkg.sv
// Shared op codes and data width for the cft ALU.
// RUNIT select values; 11xx decodes as idle.
package cft_alu_pkg;
    localparam int WIDTH = 16;

    localparam logic [3:0] ALU_IDLE = 4'b0000;
    localparam logic [3:0] ALU_ROLL = 4'b0100;
    localparam logic [3:0] ALU_NOT  = 4'b0101;
    localparam logic [3:0] ALU_CS1  = 4'b0110;
    localparam logic [3:0] ALU_CS2  = 4'b0111;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;

    // True for op codes that produce a result onto the bus.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3:2] == 2'b01) || (op[3:2] == 2'b10);
    endfunction
endpackage

// File: rtl/cft_alu_phase_gen.sv
// Free-running 4-phase sequencer; wraps 3 -> 0, restarts at 0 after reset.
module cft_alu_phase_gen (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] phase
);
    always_ff @(posedge clk) begin
        if (reset) phase <= 2'd0;
        else       phase <= phase + 2'd1;
    end
endmodule

// File: rtl/cft_alu_core.sv
// 16-bit ALU: B register loaded from ibus, combinational result driven back onto
// ibus, ADD/ROLL flags and a phase-3 flag-write strobe.
module cft_alu_core #(
    parameter int WIDTH = cft_alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       runit,
    input  logic [15:0]      ir,
    input  logic [WIDTH-1:0] ac,
    input  logic             fl,
    input  logic             nwalu,
    inout  wire  [WIDTH-1:0] ibus,
    output logic             nflstrobe,
    output logic             fv,
    output logic             nfltadd,
    output logic             roll16,
    output logic             isroll,
    output logic [1:0]       phase
);
    import cft_alu_pkg::*;

    logic [WIDTH-1:0]     b_reg;
    logic [3:0]           op;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       rot;
    logic [2*WIDTH+1:0]   rot_dbl;
    logic [WIDTH-1:0]     result;
    logic                 drive;
    logic                 unused_ir;

    assign unused_ir = ^ir[15:4];

    // Reset forces the select idle so flags and the bus drop in the same cycle.
    assign op    = reset ? ALU_IDLE : runit;
    assign drive = is_alu_op(op);

    always_ff @(posedge clk) begin
        if (reset)       b_reg <= '0;
        else if (!nwalu) b_reg <= ibus;
    end

    assign sum     = {1'b0, ac} + {1'b0, b_reg} + {{WIDTH{1'b0}}, fl};
    // Rotate {fl,ac} by taking the top half of the doubled word after a left shift.
    assign rot_dbl = {fl, ac, fl, ac} << ir[3:0];
    assign rot     = rot_dbl[2*WIDTH+1:WIDTH+1];

    always_comb begin
        result = ac;
        case (op)
            ALU_ROLL: result = rot[WIDTH-1:0];
            ALU_NOT:  result = ~ac;
            ALU_CS1:  result = b_reg;
            ALU_CS2:  result = ac;
            ALU_ADD:  result = sum[WIDTH-1:0];
            ALU_AND:  result = ac & b_reg;
            ALU_OR:   result = ac | b_reg;
            ALU_XOR:  result = ac ^ b_reg;
            default:  result = ac;
        endcase
    end

    assign ibus = drive ? result : {WIDTH{1'bz}};

    assign nfltadd = (op == ALU_ADD) ? ~sum[WIDTH] : 1'b1;
    assign fv      = (op == ALU_ADD) && (ac[WIDTH-1] == b_reg[WIDTH-1])
                     && (sum[WIDTH-1] != ac[WIDTH-1]);
    assign isroll  = (op == ALU_ROLL);
    assign roll16  = isroll & rot[WIDTH];

    cft_alu_phase_gen u_phase (
        .clk   (clk),
        .reset (reset),
        .phase (phase)
    );

    // Registered off phase 2 so the strobe is low exactly during phase 3.
    always_ff @(posedge clk) begin
        if (reset) nflstrobe <= 1'b1;
        else       nflstrobe <= ~((phase == 2'd2) && (op == ALU_ADD || op == ALU_ROLL));
    end
endmodule

// File: tb/tb_cft_alu_core.sv
// Directed bench for cft_alu_core: op results, flags, bus release, strobe timing, reset.
module tb_cft_alu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  runit = 4'b0000;
    logic [15:0] ir = '0;
    logic [15:0] ac = '0;
    logic        fl = 1'b0;
    logic        nwalu = 1'b1;
    logic [15:0] bus_drv = '0;
    logic        bus_en = 1'b0;
    wire  [15:0] ibus;
    logic        nflstrobe, fv, nfltadd, roll16, isroll;
    logic [1:0]  phase;
    logic [1:0]  ph_model;
    int          checks = 0;
    int          errors = 0;

    assign ibus = bus_en ? bus_drv : 16'hzzzz;

    cft_alu_core dut (
        .clk(clk), .reset(reset), .runit(runit), .ir(ir), .ac(ac), .fl(fl),
        .nwalu(nwalu), .ibus(ibus), .nflstrobe(nflstrobe), .fv(fv),
        .nfltadd(nfltadd), .roll16(roll16), .isroll(isroll), .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) ph_model <= 2'd0;
        else       ph_model <= ph_model + 2'd1;
    end

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // Undriven bus reads as Z (4-state) or 0 (2-state); the would-be results are nonzero.
    function automatic logic released();
        return (ibus === 16'hzzzz) || (ibus === 16'h0000);
    endfunction

    task automatic load_b(input logic [15:0] v);
        @(negedge clk);
        runit = 4'b0000; bus_drv = v; bus_en = 1'b1; nwalu = 1'b0;
        @(negedge clk);
        nwalu = 1'b1; bus_en = 1'b0;
    endtask

    task automatic set_op(input logic [3:0] r, input logic [15:0] a, input logic f);
        runit = r; ac = a; fl = f;
        #1;
    endtask

    initial begin
        logic [15:0] av, bv;
        int lows;

        repeat (3) @(negedge clk);
        chk("rst_nflstrobe", {15'd0, nflstrobe}, 16'd1);
        chk("rst_phase", {14'd0, phase}, 16'd0);
        chk("rst_nfltadd", {15'd0, nfltadd}, 16'd1);
        chk("rst_fv", {15'd0, fv}, 16'd0);
        chk("rst_isroll", {15'd0, isroll}, 16'd0);
        runit = 4'b1000; ac = 16'h1234; #1;
        chk("rst_bus_rel", {15'd0, released()}, 16'd1);
        @(negedge clk);
        reset = 1'b0; runit = 4'b0000;

        // OR directed
        load_b(16'h0F0F);
        set_op(4'b1010, 16'h5431, 1'b0);
        chk("or_bus", ibus, 16'h5F3F);
        chk("or_nfltadd", {15'd0, nfltadd}, 16'd1);
        chk("or_fv", {15'd0, fv}, 16'd0);
        chk("or_isroll", {15'd0, isroll}, 16'd0);
        chk("or_roll16", {15'd0, roll16}, 16'd0);

        // ADD
        load_b(16'h0001);
        set_op(4'b1000, 16'hFFFF, 1'b0);
        chk("add_wrap_bus", ibus, 16'h0000);
        chk("add_wrap_nfltadd", {15'd0, nfltadd}, 16'd0);
        chk("add_wrap_fv", {15'd0, fv}, 16'd0);
        set_op(4'b1000, 16'h7FFF, 1'b0);
        chk("add_ovf_bus", ibus, 16'h8000);
        chk("add_ovf_nfltadd", {15'd0, nfltadd}, 16'd1);
        chk("add_ovf_fv", {15'd0, fv}, 16'd1);
        set_op(4'b1000, 16'h1234, 1'b1);
        chk("add_cin_bus", ibus, 16'h1236);

        // ROLL
        ir = 16'h0001;
        set_op(4'b0100, 16'h8001, 1'b0);
        chk("roll1_bus", ibus, 16'h0002);
        chk("roll1_isroll", {15'd0, isroll}, 16'd1);
        chk("roll1_roll16", {15'd0, roll16}, 16'd1);
        chk("roll1_nfltadd", {15'd0, nfltadd}, 16'd1);
        ir = 16'h0000; #1;
        chk("roll0_bus", ibus, 16'h8001);
        chk("roll0_roll16", {15'd0, roll16}, 16'd0);
        ir = 16'hFFF4;
        set_op(4'b0100, 16'h0000, 1'b1);
        chk("roll4_bus", ibus, 16'h0008);
        chk("roll4_roll16", {15'd0, roll16}, 16'd0);
        ir = 16'h000F;
        set_op(4'b0100, 16'h0001, 1'b0);
        chk("roll15_bus", ibus, 16'h8000);
        chk("roll15_roll16", {15'd0, roll16}, 16'd0);

        // Strobe: ROLL held; low exactly in phase 3
        ir = 16'h0001;
        set_op(4'b0100, 16'h8001, 1'b0);
        @(negedge clk);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("phase_seq", {14'd0, phase}, {14'd0, ph_model});
            chk("strobe_roll", {15'd0, nflstrobe}, (ph_model == 2'd3) ? 16'd0 : 16'd1);
            if (!nflstrobe) lows++;
        end
        chk("strobe_count", lows[15:0], 16'd2);
        runit = 4'b1010;
        repeat (4) begin
            @(negedge clk);
            chk("strobe_or_hi", {15'd0, nflstrobe}, 16'd1);
        end

        // Idle / bus release, B load, NOT/CS1/CS2/AND/XOR
        set_op(4'b0000, 16'h1234, 1'b0);
        chk("idle_rel", {15'd0, released()}, 16'd1);
        chk("idle_nfltadd", {15'd0, nfltadd}, 16'd1);
        set_op(4'b1100, 16'h1234, 1'b0);
        chk("idle11_rel", {15'd0, released()}, 16'd1);
        load_b(16'hA5A5);
        set_op(4'b0101, 16'h1234, 1'b0);
        chk("not_bus", ibus, 16'hEDCB);
        set_op(4'b0110, 16'h1234, 1'b0);
        chk("cs1_bus", ibus, 16'hA5A5);
        set_op(4'b0111, 16'h1234, 1'b0);
        chk("cs2_bus", ibus, 16'h1234);
        set_op(4'b1001, 16'h0FF0, 1'b0);
        chk("and_bus", ibus, 16'h05A0);
        set_op(4'b1011, 16'h0FF0, 1'b0);
        chk("xor_bus", ibus, 16'hAA55);

        // Reset mid-ADD
        @(negedge clk);
        set_op(4'b1000, 16'h7FFF, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1; #1;
        chk("rstop_rel", {15'd0, released()}, 16'd1);
        chk("rstop_fv", {15'd0, fv}, 16'd0);
        chk("rstop_nfltadd", {15'd0, nfltadd}, 16'd1);
        @(negedge clk);
        chk("rstop_nflstrobe", {15'd0, nflstrobe}, 16'd1);
        chk("rstop_phase", {14'd0, phase}, 16'd0);
        reset = 1'b0;
        set_op(4'b0110, 16'h1234, 1'b0);
        chk("rstop_b_clr", ibus, 16'h0000);
        @(negedge clk);
        chk("rstop_phase1", {14'd0, phase}, 16'd1);

        // OR sweep: 1024 B values x 1024 ac values, stride 21553
        for (int j = 0; j < 1024; j++) begin
            bv = 16'(j * 21553);
            load_b(bv);
            runit = 4'b1010;
            for (int i = 0; i < 1024; i++) begin
                av = 16'(i * 21553 + 7);
                ac = av; #1;
                chk("or_sweep", ibus, av | bv);
            end
            runit = 4'b0000;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
